// File: rtl/netbus_rx_arbiter_pkg.sv
// Shared NetBus definitions for the receive arbiter: flit geometry, port-id
// sizing and the arbiter state encoding.
package netbus_rx_arbiter_pkg;

   localparam int LAST_BIT = 0;

   typedef enum logic {
      ST_IDLE,
      ST_LOCK
   } arb_state_t;

   function automatic int flit_width(input int data_width);
      return data_width * 9 + 14;
   endfunction

   function automatic int pid_width(input int num_ports);
      return $clog2(num_ports + 1);
   endfunction

endpackage

// File: rtl/netbus_rx_arbiter_if.sv
// NetBus receive-merge bundle: per-port input lanes plus the merged output
// stream and grant status.
interface netbus_rx_arbiter_if
   import netbus_rx_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 8,
   parameter int W         = flit_width(4),
   parameter int PID_W     = pid_width(NUM_PORTS)
);

   logic [NUM_PORTS*W-1:0] IDATA;
   logic [NUM_PORTS-1:0]   IVALID;
   logic [NUM_PORTS-1:0]   IFRAME;
   logic [NUM_PORTS-1:0]   IREADY;
   logic [W-1:0]           ODATA;
   logic                   OVALID;
   logic                   OREADY;
   logic [PID_W-1:0]       GRANT_ID;
   logic                   BUSY;

   modport master (
      output IDATA, IVALID, IFRAME, OREADY,
      input  IREADY, ODATA, OVALID, GRANT_ID, BUSY
   );

   modport slave (
      input  IDATA, IVALID, IFRAME, OREADY,
      output IREADY, ODATA, OVALID, GRANT_ID, BUSY
   );

endinterface

// File: rtl/netbus_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping at N-1.
module netbus_rr_pick
   import netbus_rx_arbiter_pkg::*;
#(
   parameter int N  = 8,
   parameter int PW = 4
)
(
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] id,
   output logic          found
);

   int idx;

   always_comb begin
      gnt   = '0;
      id    = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            id       = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/netbus_rx_arbiter.sv
// Frame-locked two-class round-robin arbiter merging NetBus receive ports
// onto one stream through a single registered output slot.
module netbus_rx_arbiter
   import netbus_rx_arbiter_pkg::*;
#(
   parameter int                   DATA_WIDTH = 4,
   parameter int                   NUM_PORTS  = 8,
   parameter logic [NUM_PORTS-1:0] RT_MASK    = '0,
   parameter int                   PID_W      = pid_width(NUM_PORTS)
)
(
   input logic                CLK,
   input logic                RESET,
   netbus_rx_arbiter_if.slave bus
);

   localparam int W = flit_width(DATA_WIDTH);

   arb_state_t           state, state_n;
   logic [PID_W-1:0]     grant_id, grant_n;
   logic [NUM_PORTS-1:0] grant_oh, grant_oh_n;
   logic [PID_W-1:0]     rt_ptr, rt_ptr_n, nrm_ptr, nrm_ptr_n;
   logic [W-1:0]         odata, sel_data;
   logic                 ovalid, busy, take, xfer, last_xfer;
   logic [NUM_PORTS-1:0] eligible, rt_req, nrm_req, iready;
   logic [NUM_PORTS-1:0] rt_gnt, nrm_gnt;
   logic [PID_W-1:0]     rt_id, nrm_id;
   logic                 rt_found, nrm_found;

   function automatic logic [PID_W-1:0] wrap_inc(input logic [PID_W-1:0] p);
      return (p == PID_W'(NUM_PORTS - 1)) ? '0 : p + 1'b1;
   endfunction

   assign eligible = (RT_MASK & bus.IVALID) | (~RT_MASK & bus.IFRAME);
   assign rt_req   = eligible & RT_MASK;
   assign nrm_req  = eligible & ~RT_MASK;

   netbus_rr_pick #(.N(NUM_PORTS), .PW(PID_W)) u_rt_pick (
      .req(rt_req), .ptr(rt_ptr), .gnt(rt_gnt), .id(rt_id), .found(rt_found)
   );

   netbus_rr_pick #(.N(NUM_PORTS), .PW(PID_W)) u_nrm_pick (
      .req(nrm_req), .ptr(nrm_ptr), .gnt(nrm_gnt), .id(nrm_id), .found(nrm_found)
   );

   // The registered one-hot grant drives IREADY directly, so no decoder sits
   // between the state register and the per-port ready lines.
   assign busy   = (state == ST_LOCK);
   assign take   = !ovalid | bus.OREADY;
   assign iready = (take && busy) ? grant_oh : '0;
   assign xfer   = |(bus.IVALID & iready);

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_oh[i]) sel_data = bus.IDATA[i*W +: W];
      end
   end

   assign last_xfer = xfer & sel_data[LAST_BIT];

   always_comb begin
      state_n    = state;
      grant_n    = grant_id;
      grant_oh_n = grant_oh;
      rt_ptr_n   = rt_ptr;
      nrm_ptr_n  = nrm_ptr;
      // Re-arbitrating on the last-beat edge gives back-to-back frames.
      if (state == ST_IDLE || last_xfer) begin
         if (rt_found) begin
            state_n    = ST_LOCK;
            grant_n    = rt_id;
            grant_oh_n = rt_gnt;
            rt_ptr_n   = wrap_inc(rt_id);
         end else if (nrm_found) begin
            state_n    = ST_LOCK;
            grant_n    = nrm_id;
            grant_oh_n = nrm_gnt;
            nrm_ptr_n  = wrap_inc(nrm_id);
         end else begin
            state_n    = ST_IDLE;
            grant_n    = PID_W'(NUM_PORTS);
            grant_oh_n = '0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= ST_IDLE;
         grant_id <= PID_W'(NUM_PORTS);
         grant_oh <= '0;
         rt_ptr   <= '0;
         nrm_ptr  <= '0;
      end else begin
         state    <= state_n;
         grant_id <= grant_n;
         grant_oh <= grant_oh_n;
         rt_ptr   <= rt_ptr_n;
         nrm_ptr  <= nrm_ptr_n;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         odata  <= '0;
         ovalid <= 1'b0;
      end else if (xfer) begin
         odata  <= sel_data;
         ovalid <= 1'b1;
      end else if (bus.OREADY) begin
         ovalid <= 1'b0;
      end
   end

   assign bus.IREADY   = iready;
   assign bus.ODATA    = odata;
   assign bus.OVALID   = ovalid;
   assign bus.GRANT_ID = grant_id;
   assign bus.BUSY     = busy;

endmodule

// File: tb/tb_netbus_rx_arbiter.sv
// Directed bench for netbus_rx_arbiter: per-port frame queues feed the DUT and
// accepted output flits are logged and compared with hand-derived sequences.
module tb_netbus_rx_arbiter;

   localparam int NP = 8;
   localparam int W  = 50;
   localparam int PW = 4;

   logic clk;
   logic reset;

   netbus_rx_arbiter_if #(.NUM_PORTS(NP), .W(W), .PID_W(PW)) bus ();

   netbus_rx_arbiter #(
      .DATA_WIDTH(4), .NUM_PORTS(NP), .RT_MASK(8'h80), .PID_W(PW)
   ) dut (
      .CLK(clk), .RESET(reset), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [W-1:0] q [NP][$];
   bit           hold [NP];
   logic [W-1:0] outlog [$];
   int           outcyc [$];
   int           order [$];
   int           cyc;
   int           nvec;
   int           nerr;

   function automatic logic [W-1:0] mk(input int p, input int s, input bit l);
      return (W'(p) << 9) | (W'(s) << 1) | W'(l);
   endfunction

   // IFRAME counts only frames not yet being read, so a granted port stops
   // advertising the frame it is currently sending.
   task automatic drive();
      for (int i = 0; i < NP; i++) begin
         int f;
         logic [W-1:0] t;
         f = 0;
         for (int k = 0; k < q[i].size(); k++) begin
            t = q[i][k];
            if (t[0]) f++;
         end
         if (bus.BUSY && int'(bus.GRANT_ID) == i && f > 0) f--;
         bus.IDATA[i*W +: W] = (q[i].size() > 0) ? q[i][0] : '0;
         bus.IVALID[i]       = (q[i].size() > 0) && !hold[i];
         bus.IFRAME[i]       = (f > 0);
      end
   endtask

   task automatic tick();
      bit hs [NP];
      for (int i = 0; i < NP; i++) hs[i] = bus.IVALID[i] & bus.IREADY[i];
      if (bus.OVALID && bus.OREADY && !reset) begin
         outlog.push_back(bus.ODATA);
         outcyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NP; i++) begin
         if (hs[i] && !reset) void'(q[i].pop_front());
      end
      drive();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.OREADY = 1'b1;
      for (int i = 0; i < NP; i++) begin
         q[i].delete();
         hold[i] = 1'b0;
      end
      drive();
      tick();
      tick();
      reset = 1'b0;
      outlog.delete();
      outcyc.delete();
   endtask

   task automatic load_frame(input int p, input int first_seq, input int len);
      for (int s = 0; s < len; s++) q[p].push_back(mk(p, first_seq + s, s == len - 1));
   endtask

   task automatic wait_outs(input int n, input int max_cycles, input string name);
      int c;
      c = 0;
      while (outlog.size() < n && c < max_cycles) begin
         tick();
         c++;
      end
      nvec++;
      if (outlog.size() < n) begin
         nerr++;
         $display("[TB] FAIL %s timeout: got %0d flits, need %0d", name, outlog.size(), n);
      end
   endtask

   task automatic get_order();
      bit first;
      logic [W-1:0] t;
      order.delete();
      first = 1'b1;
      for (int k = 0; k < outlog.size(); k++) begin
         t = outlog[k];
         if (first) order.push_back(int'(t[12:9]));
         first = t[0];
      end
   endtask

   task automatic test_reset();
      do_reset();
      nvec++; if (bus.OVALID !== 1'b0) begin nerr++; $display("[TB] FAIL reset_ovalid got %b want 0", bus.OVALID); end
      nvec++; if (bus.ODATA !== '0) begin nerr++; $display("[TB] FAIL reset_odata got %h want 0", bus.ODATA); end
      nvec++; if (bus.GRANT_ID !== 4'd8) begin nerr++; $display("[TB] FAIL reset_grant got %0d want 8", bus.GRANT_ID); end
      nvec++; if (bus.BUSY !== 1'b0) begin nerr++; $display("[TB] FAIL reset_busy got %b want 0", bus.BUSY); end
      nvec++; if (bus.IREADY !== 8'h00) begin nerr++; $display("[TB] FAIL reset_iready got %h want 00", bus.IREADY); end
   endtask

   task automatic test_basic_merge();
      int first_rdy, c;
      logic [NP-1:0] rdy_val;
      do_reset();
      load_frame(3, 0, 4);
      drive();
      first_rdy = -1;
      rdy_val = '0;
      c = 0;
      while (outlog.size() < 4 && c < 30) begin
         tick();
         c++;
         if (first_rdy < 0 && bus.IREADY[3]) begin
            first_rdy = cyc;
            rdy_val = bus.IREADY;
         end
      end
      nvec++; if (outlog.size() != 4) begin nerr++; $display("[TB] FAIL basic_count got %0d want 4", outlog.size()); end
      nvec++; if (rdy_val !== 8'h08) begin nerr++; $display("[TB] FAIL basic_iready got %h want 08", rdy_val); end
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (outlog[k] !== mk(3, k, k == 3)) begin
            nerr++; $display("[TB] FAIL basic_flit%0d got %h want %h", k, outlog[k], mk(3, k, k == 3));
         end
         nvec++;
         if (outcyc[k] != first_rdy + 1 + k) begin
            nerr++; $display("[TB] FAIL basic_cycle%0d got %0d want %0d", k, outcyc[k], first_rdy + 1 + k);
         end
      end
      nvec++; if (bus.GRANT_ID !== 4'd8) begin nerr++; $display("[TB] FAIL basic_grant_after got %0d want 8", bus.GRANT_ID); end
      nvec++; if (bus.BUSY !== 1'b0) begin nerr++; $display("[TB] FAIL basic_busy_after got %b want 0", bus.BUSY); end
   endtask

   task automatic test_round_robin();
      int exp_order [6] = '{1, 2, 5, 1, 2, 5};
      int fr [3] = '{0, 0, 0};
      int pidx;
      int seq;
      do_reset();
      load_frame(1, 0, 2); load_frame(1, 2, 2);
      load_frame(2, 0, 2); load_frame(2, 2, 2);
      load_frame(5, 0, 2); load_frame(5, 2, 2);
      drive();
      wait_outs(12, 60, "rr");
      get_order();
      for (int k = 0; k < 6; k++) begin
         nvec++;
         if (order[k] != exp_order[k]) begin
            nerr++; $display("[TB] FAIL rr_order%0d got %0d want %0d", k, order[k], exp_order[k]);
         end
      end
      for (int k = 0; k < 12; k++) begin
         pidx = (k / 2) % 3;
         seq = fr[pidx] * 2 + (k % 2);
         if (k % 2 == 1) fr[pidx]++;
         nvec++;
         if (outlog[k] !== mk(exp_order[k/2], seq, k % 2 == 1)) begin
            nerr++; $display("[TB] FAIL rr_flit%0d got %h want %h", k, outlog[k], mk(exp_order[k/2], seq, k % 2 == 1));
         end
      end
      nvec++;
      if (outcyc[11] - outcyc[0] != 11) begin
         nerr++; $display("[TB] FAIL rr_no_bubble got span %0d want 11", outcyc[11] - outcyc[0]);
      end
   endtask

   task automatic test_priority();
      do_reset();
      load_frame(0, 0, 4);
      load_frame(1, 0, 2);
      drive();
      wait_outs(1, 20, "prio_start");
      load_frame(7, 0, 2);
      drive();
      #1;
      nvec++; if (bus.GRANT_ID !== 4'd0) begin nerr++; $display("[TB] FAIL prio_no_preempt got %0d want 0", bus.GRANT_ID); end
      nvec++; if (bus.IREADY[7] !== 1'b0) begin nerr++; $display("[TB] FAIL prio_iready7 got %b want 0", bus.IREADY[7]); end
      wait_outs(6, 30, "prio");
      for (int k = 0; k < 6; k++) begin
         logic [W-1:0] e;
         e = (k < 4) ? mk(0, k, k == 3) : mk(7, k - 4, k == 5);
         nvec++;
         if (outlog[k] !== e) begin
            nerr++; $display("[TB] FAIL prio_flit%0d got %h want %h", k, outlog[k], e);
         end
      end
   endtask

   task automatic test_backpressure();
      bit pat [10] = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
      logic [W-1:0] held;
      int stalls;
      do_reset();
      load_frame(2, 0, 3);
      drive();
      tick();
      stalls = 0;
      for (int k = 0; k < 10; k++) begin
         bus.OREADY = pat[k];
         #1;
         if (bus.OVALID && !bus.OREADY) begin
            stalls++;
            nvec++;
            if (bus.IREADY !== 8'h00) begin nerr++; $display("[TB] FAIL bp_iready%0d got %h want 00", k, bus.IREADY); end
            held = bus.ODATA;
            tick();
            nvec++;
            if (bus.ODATA !== held) begin nerr++; $display("[TB] FAIL bp_stable%0d got %h want %h", k, bus.ODATA, held); end
         end else begin
            tick();
         end
      end
      bus.OREADY = 1'b1;
      nvec++; if (stalls != 2) begin nerr++; $display("[TB] FAIL bp_stalls got %0d want 2", stalls); end
      nvec++; if (outlog.size() != 3) begin nerr++; $display("[TB] FAIL bp_count got %0d want 3", outlog.size()); end
      for (int k = 0; k < 3; k++) begin
         nvec++;
         if (outlog[k] !== mk(2, k, k == 2)) begin
            nerr++; $display("[TB] FAIL bp_flit%0d got %h want %h", k, outlog[k], mk(2, k, k == 2));
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      load_frame(3, 0, 4);
      drive();
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      nvec++; if (bus.OVALID !== 1'b0) begin nerr++; $display("[TB] FAIL midrst_ovalid got %b want 0", bus.OVALID); end
      nvec++; if (bus.GRANT_ID !== 4'd8) begin nerr++; $display("[TB] FAIL midrst_grant got %0d want 8", bus.GRANT_ID); end
      nvec++; if (bus.IREADY !== 8'h00) begin nerr++; $display("[TB] FAIL midrst_iready got %h want 00", bus.IREADY); end
      reset = 1'b0;
      q[3].delete();
      outlog.delete();
      outcyc.delete();
      load_frame(5, 0, 2);
      load_frame(0, 0, 2);
      drive();
      wait_outs(2, 20, "midrst_after");
      get_order();
      nvec++; if (order[0] != 0) begin nerr++; $display("[TB] FAIL midrst_first_port got %0d want 0", order[0]); end
   endtask

   task automatic test_single_beat();
      int exp_order [6] = '{0, 4, 0, 4, 0, 4};
      do_reset();
      for (int s = 0; s < 3; s++) begin
         load_frame(0, s, 1);
         load_frame(4, s, 1);
      end
      drive();
      wait_outs(6, 40, "single");
      get_order();
      for (int k = 0; k < 6; k++) begin
         nvec++;
         if (order[k] != exp_order[k]) begin
            nerr++; $display("[TB] FAIL single_order%0d got %0d want %0d", k, order[k], exp_order[k]);
         end
      end
      nvec++;
      if (outcyc[5] - outcyc[0] != 5) begin
         nerr++; $display("[TB] FAIL single_rate got span %0d want 5", outcyc[5] - outcyc[0]);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      nvec = 0;
      nerr = 0;
      cyc = 0;
      reset = 1'b1;
      bus.OREADY = 1'b1;
      bus.IDATA = '0;
      bus.IVALID = '0;
      bus.IFRAME = '0;
      test_reset();
      test_basic_merge();
      test_round_robin();
      test_priority();
      test_backpressure();
      test_reset_mid_frame();
      test_single_beat();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/netbus_rx_arbiter.md
Name: netbus_rx_arbiter

Overview:
N-port, single-clock frame arbiter for NetBus receive traffic, parametrised in port count and flit width. It is placed after the per-port clock-crossing slices, which have already moved every port into the CLK domain. It merges the ports onto one NetBus stream with a registered output stage. Each grant is locked for a whole frame, and two priority classes apply: real-time ports are served before normal ports, with round-robin fairness inside each class.

Parameters:
DATA_WIDTH, 4, NetBus lane parameter; flit width W = DATA_WIDTH*9+14.
NUM_PORTS, 8, number of input ports, 2..16.
RT_MASK, {NUM_PORTS{1'b0}}, bit i=1 makes port i real-time (eligible on IVALID[i]; otherwise eligible on IFRAME[i]).
PID_W, $clog2(NUM_PORTS+1), width of the port-id field.

Ports:
CLK  in  1  single clock; all logic is rising-edge.
RESET  in  1  synchronous, active-high reset.
IDATA  in  NUM_PORTS*W  flit of port i at [i*W +: W]; bit 0 of each flit = last-beat flag.
IVALID  in  NUM_PORTS  per-port flit valid.
IFRAME  in  NUM_PORTS  per-port flag: at least one complete frame is buffered.
IREADY  out  NUM_PORTS  per-port ready; at most one bit is set (one-hot or zero).
ODATA  out  W  merged flit (registered).
OVALID  out  1  merged valid (registered).
OREADY  in  1  downstream ready.
GRANT_ID  out  PID_W  currently locked port; NUM_PORTS = none.
BUSY  out  1  1 while a frame is locked.

Behaviour:
- Reset (RESET=1 at a CLK edge): OVALID=0, ODATA=0, GRANT_ID=NUM_PORTS, BUSY=0, both round-robin pointers=0, state=IDLE. Reset applied mid-frame abandons the frame and drops the output register contents.
- Output stage: one register slot. take = !OVALID | OREADY.
- IREADY[g] = take & BUSY, where g = GRANT_ID. All other IREADY bits are 0.
- Input transfer on port g: IVALID[g] & IREADY[g]. The flit is loaded into ODATA and OVALID=1 on the next edge. Latency is one cycle.
- When OVALID & OREADY and no new transfer occurs, OVALID clears.
- Throughput: one flit per cycle sustained.
- FSM states:
  - IDLE: if any port is eligible, go to LOCK with GRANT_ID=winner and BUSY=1 at the next edge. Otherwise stay in IDLE.
  - LOCK: stay in LOCK until a transfer occurs with IDATA bit 0 = 1.
  - On that last-beat transfer edge, arbitration runs again in the same cycle. If a port is eligible, its grant starts at once (back-to-back, no bubble). Otherwise go to IDLE with GRANT_ID=NUM_PORTS and BUSY=0.
- Arbitration:
  - Eligibility: e[i] = RT_MASK[i] ? IVALID[i] : IFRAME[i].
  - If any RT port is eligible, choose among RT ports. Otherwise choose among normal ports.
  - Within a class, the search starts at that class pointer and rotates upward, wrapping from NUM_PORTS-1 to 0.
  - On a grant, the winning class pointer becomes winner+1, wrapping to 0 when winner = NUM_PORTS-1. The other class pointer is unchanged.
- The grant never changes mid-frame, even when a higher-priority port becomes eligible.
- IVALID deasserting mid-frame on the granted port stalls the merge without releasing the lock.
- Single-beat frame (bit 0 = 1 on the first flit): lock and release complete in one transfer.
- Eligibility of the currently granted port is re-evaluated at release, so the same port can win again only if it is the only eligible port, or the rotation reaches it.
- Downstream backpressure (OREADY=0 with OVALID=1) holds ODATA stable and forces IREADY=0.

Decomposition:
- Shared netbus package holds: the flit-width function W(DATA_WIDTH), the constant LAST_BIT=0, and the port-id width function.
- One sub-module, netbus_rr_pick (parametrised N), takes request vector + pointer and returns a one-hot grant + encoded id + found flag. It is instantiated twice, once for the RT class and once for the normal class.

Test Plan:
- Basic merge: NUM_PORTS=8, port 3 frame of 4 flits (last on the 4th), OREADY=1 -> ODATA carries the 4 flits on consecutive cycles starting 1 cycle after the first IREADY[3]; GRANT_ID=8 and BUSY=0 afterwards.
- Round-robin: ports 1, 2 and 5 each hold two 2-flit frames (normal class) -> grant order 1,2,5,1,2,5 with no idle cycle between frames.
- Priority: RT_MASK=8'h80; port 0 mid-frame when port 7 raises IVALID -> port 0 finishes; port 7 is granted next, ahead of pending normal port 1.
- Backpressure: OREADY toggles 1,0,0,1 during a 3-flit frame -> no flit lost or duplicated; IREADY=0 on the stalled cycles; ODATA stable while OVALID & !OREADY.
- Reset mid-frame: RESET=1 on flit 2 of 4 -> the next cycle shows OVALID=0, GRANT_ID=8, IREADY=0; the first frame after reset is served from port 0 (pointer=0).
- Single-beat frames: ports 0 and 4 each send 1-flit frames continuously -> alternating grants 0,4,0,4 at one flit per cycle.
